// File: rtl/audio_pkg.sv
// audio_pkg: shared types and constants for the audio capture path.
//   SAMPLE_W        width of one channel sample
//   CH_LEFT/CH_RIGHT bit positions of the left/right strobes in sample_end
//   stereo_frame_t  one stereo frame, left in the upper half
//   pair_state_t    left/right pairing state
package audio_pkg;

  localparam int SAMPLE_W = 16;

  localparam int CH_LEFT  = 1;
  localparam int CH_RIGHT = 0;

  typedef struct packed {
    logic [SAMPLE_W-1:0] left;
    logic [SAMPLE_W-1:0] right;
  } stereo_frame_t;

  typedef enum logic {
    WAIT_L = 1'b0,
    HAVE_L = 1'b1
  } pair_state_t;

endpackage

// File: rtl/audio_frame_fifo.sv
// audio_frame_fifo: generic synchronous first-word-fall-through FIFO.
//   clk, reset      clock, asynchronous active-high reset
//   flush           synchronous clear of pointers and level (overrides push/pop)
//   push, push_data write request and data; accepted when not full or when
//                   a pop happens in the same cycle
//   pop             consumer takes the head word; ignored while empty
//   pop_data        head word, valid while empty is low
//   full, empty     derived from level
//   level           words stored, 0..DEPTH
module audio_frame_fifo #(
  parameter  int WIDTH = 32,
  parameter  int DEPTH = 64,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Pointers wrap modulo DEPTH, so pointer equality is ambiguous; the level
  // counter alone decides full and empty.
  assign empty   = (level == '0);
  assign full    = (level == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  // When full, a same-cycle pop frees the slot the push writes into.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // NOTE: the storage array has no reset; stale words are never visible
  // because empty masks them, and a reset port would prevent RAM inference.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

  assign pop_data = mem[rd_ptr];

endmodule

// File: rtl/audio_capture_fifo.sv
// audio_capture_fifo: pairs codec left/right ADC words into stereo frames,
// buffers them in a FWFT FIFO and tracks dropped frames.
//   clk, reset        codec clock, asynchronous active-high reset
//   enable            capture enable; low forces pairing back to WAIT_L
//   flush             synchronous clear of FIFO, pairing and overflow status
//   sample_end[1:0]   left/right word strobes (CH_LEFT, CH_RIGHT)
//   audio_input_l/r   ADC words qualified by their strobe
//   out_valid/ready   frame handshake, out_data = {left, right}
//   level             frames stored
//   overflow          sticky: at least one frame dropped
//   drop_count        dropped frames, saturating
module audio_capture_fifo #(
  parameter  int SAMPLE_W = audio_pkg::SAMPLE_W,
  parameter  int DEPTH    = 64,
  localparam int AW       = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  flush,
  input  logic [1:0]            sample_end,
  input  logic [SAMPLE_W-1:0]   audio_input_l,
  input  logic [SAMPLE_W-1:0]   audio_input_r,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [2*SAMPLE_W-1:0] out_data,
  output logic [AW:0]           level,
  output logic                  overflow,
  output logic [15:0]           drop_count
);

  import audio_pkg::*;

  pair_state_t           state;
  pair_state_t           state_next;
  logic [SAMPLE_W-1:0]   hold_l;
  logic [SAMPLE_W-1:0]   hold_l_next;
  logic                  push;
  logic [2*SAMPLE_W-1:0] push_data;
  logic                  full;
  logic                  empty;
  logic                  drop;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= WAIT_L;
      hold_l <= '0;
    end else begin
      state  <= state_next;
      hold_l <= hold_l_next;
    end
  end

  // NOTE: every output of this block gets a default first so no path leaves
  // a variable unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next  = state;
    hold_l_next = hold_l;
    push        = 1'b0;
    push_data   = {hold_l, audio_input_r};
    if (flush || !enable) begin
      // Any half-formed frame is abandoned.
      state_next = WAIT_L;
    end else if (sample_end == 2'b11) begin
      // Both words in the same cycle bypass the holding register.
      push       = 1'b1;
      push_data  = {audio_input_l, audio_input_r};
      state_next = WAIT_L;
    end else begin
      case (state)
        WAIT_L: begin
          // A right word without a preceding left word is an orphan.
          if (sample_end[CH_LEFT]) begin
            hold_l_next = audio_input_l;
            state_next  = HAVE_L;
          end
        end
        HAVE_L: begin
          if (sample_end[CH_RIGHT]) begin
            push       = 1'b1;
            state_next = WAIT_L;
          end else if (sample_end[CH_LEFT]) begin
            hold_l_next = audio_input_l;
          end
        end
        default: state_next = WAIT_L;
      endcase
    end
  end

  audio_frame_fifo #(
    .WIDTH (2*SAMPLE_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .push      (push),
    .push_data (push_data),
    .pop       (out_ready),
    .pop_data  (out_data),
    .full      (full),
    .empty     (empty),
    .level     (level)
  );

  assign out_valid = !empty;
  // Full implies a valid head, so out_ready alone tells whether a slot frees.
  assign drop      = push && full && !out_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end else if (flush) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (drop_count != 16'hFFFF) drop_count <= drop_count + 1'b1;
    end
  end

endmodule

// File: doc/audio_capture_fifo.md
Name: audio_capture_fifo

Overview:
- Downstream of the codec serializer; consumes the parallel ADC words (audio_input_l/r) the codec produces at each sample_end strobe.
- Pairs left and right samples into 32-bit stereo frames and buffers them in a synchronous FIFO.
- Frames drain through a valid/ready port for the DSP/host side.
- Tracks overflow (sticky flag plus saturating drop counter) so software can detect lost audio.

Parameters:
- SAMPLE_W, 16, width of one channel sample.
- DEPTH, 64, FIFO depth in frames; power of two, at least 4.
- AW, $clog2(DEPTH), FIFO address width (derived, not overridden).

Ports:
- clk  in  1  system clock, same clock as the codec.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  capture enable; 0 means no frames are formed.
- flush  in  1  synchronous clear of FIFO, pairing state and overflow status.
- sample_end  in  2  codec strobes: bit1 = left word valid, bit0 = right word valid (one-cycle pulses).
- audio_input_l  in  SAMPLE_W  left ADC word, valid while sample_end[1] is high.
- audio_input_r  in  SAMPLE_W  right ADC word, valid while sample_end[0] is high.
- out_valid  out  1  FIFO not empty.
- out_ready  in  1  consumer accepts the head frame.
- out_data  out  2*SAMPLE_W  head frame, {left[31:16], right[15:0]}.
- level  out  AW+1  frames currently stored, 0..DEPTH.
- overflow  out  1  sticky flag: a frame was dropped.
- drop_count  out  16  dropped frames, saturates at 16'hFFFF.

Behaviour:
- Reset (asynchronous) values: out_valid=0, level=0, overflow=0, drop_count=0, pointers=0, pairing FSM=WAIT_L, left holding register=0. out_data is don't-care while out_valid=0.
- Pairing FSM, two states; applies only when enable=1 and flush=0:
  - WAIT_L + sample_end[1]: latch audio_input_l into the holding register, go to HAVE_L.
  - WAIT_L + sample_end[0] alone: orphan right sample; ignore it and stay in WAIT_L.
  - HAVE_L + sample_end[0]: push {hold_l, audio_input_r}, go to WAIT_L.
  - HAVE_L + sample_end[1] alone: overwrite hold_l, stay in HAVE_L.
  - sample_end==2'b11 in either state: push {audio_input_l, audio_input_r} directly, end in WAIT_L.
- enable=0: FSM forced to WAIT_L, no pushes. FIFO draining continues normally. Deasserting enable while in HAVE_L discards the held left sample.
- Push timing: a frame pushed in cycle N is visible on out_data with out_valid=1 in cycle N+1 (first-word fall-through from registered storage).
- Pop: out_valid && out_ready in a cycle advances the read pointer. out_ready while empty has no effect.
- Level: +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
- Full (level==DEPTH) with a push and no pop: frame dropped, contents unchanged, overflow set, drop_count incremented (saturating).
- Full with a push and a pop in the same cycle: the push is accepted; no drop.
- Empty with a push and out_ready high: the frame is not popped that cycle (out_valid is still 0).
- Pointers are AW bits and wrap modulo DEPTH. Full/empty are derived from level, never from pointer equality alone.
- flush=1: next cycle level=0, out_valid=0, FSM=WAIT_L, overflow=0, drop_count=0. Flush overrides any push or pop in the same cycle. FIFO memory contents are not cleared.
- Reset asserted mid-frame: returns all state to reset values immediately. Stored frames are lost.

Decomposition:
- audio_pkg:
  - SAMPLE_W constant.
  - Channel index constants CH_LEFT=1 and CH_RIGHT=0, matching the sample_end/sample_req bit order.
  - typedef stereo_frame_t as a packed struct {left, right}.
  - Enum pair_state_t {WAIT_L, HAVE_L}.
- Sub-module audio_frame_fifo: generic synchronous FWFT FIFO with parameters WIDTH and DEPTH, ports push/pop/full/empty/level/flush. audio_capture_fifo owns the pairing FSM and the overflow statistics.

Test Plan:
- Basic frame: enable=1; left pulse with l=16'h1234, then 64 cycles later right pulse with r=16'hABCD -> one cycle after the right pulse out_valid=1, out_data=32'h1234ABCD, level=1; out_ready pulse -> level=0, out_valid=0.
- Orphan and overwrite: right pulse first (16'h0001) is ignored; left 16'h1111, left 16'h2222, right 16'h3333 -> exactly one frame, 32'h22223333.
- Overflow: out_ready=0, push DEPTH+3 frames -> level=64, overflow=1, drop_count=3, head is still the first frame; flush -> level=0, overflow=0, drop_count=0.
- Full with simultaneous push/pop: at level=64 hold out_ready=1 during a push -> level stays 64, no drop, new frame appears at the tail after 63 more pops.
- Wrap-around: stream 200 frames with out_ready=1 and a value counter -> output sequence is in order and gap-free, level never exceeds 1.
- Async reset mid-frame: assert reset in HAVE_L with 5 frames stored -> out_valid and level go to 0 immediately; the next right pulse after release produces no frame.
